// File: rtl/nios_pixel_capture.sv
// Avalon-MM camera capture controller: synchronises the camera bus, packs bytes into
// 32-bit words in a FIFO and raises IRQs. Optional test pattern: PIXCAP_TESTPATTERN_EN.
module nios_pixel_capture #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        pix_clk,
  input  logic        pix_vsync,
  input  logic        pix_href,
  input  logic [7:0]  pix_data
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_t;

  logic [SYNC_STAGES-1:0]      clk_sync, vs_sync, hr_sync;
  logic [SYNC_STAGES-1:0][7:0] data_sync;
  logic                        clk_d, vs_d, hr_d;

  state_t      state;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level, level_next;
  logic [31:0] word_buf, push_word, rd_mux;
  logic [1:0]  byte_idx;
  logic [15:0] byte_count;
  logic [11:0] line_count;
  logic [7:0]  threshold, cap_byte, data_s;
  logic [2:0]  irq_mask, irq_status, irq_set, w1c;
  logic        done, overflow, continuous, busy, tp_rd;
  logic        clk_s, vs_s, hr_s, pix_edge, vs_rise, hr_fall, cap;
  logic        rd_en, wr_en, start_req, abort_req;
  logic        push, pop, full, push_ok, push_drop, thr_hit;
  logic        unused_wd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '0;
      vs_sync   <= '0;
      hr_sync   <= '0;
      data_sync <= '0;
      clk_d     <= 1'b0;
      vs_d      <= 1'b0;
      hr_d      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], pix_clk};
      vs_sync   <= {vs_sync[SYNC_STAGES-2:0], pix_vsync};
      hr_sync   <= {hr_sync[SYNC_STAGES-2:0], pix_href};
      data_sync <= {data_sync[SYNC_STAGES-2:0], pix_data};
      clk_d     <= clk_s;
      vs_d      <= vs_s;
      hr_d      <= hr_s;
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign vs_s     = vs_sync[SYNC_STAGES-1];
  assign hr_s     = hr_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];
  assign pix_edge = clk_s & ~clk_d;
  assign vs_rise  = vs_s & ~vs_d;
  assign hr_fall  = ~hr_s & hr_d;

  assign rd_en     = chipselect & ~read_n;
  assign wr_en     = chipselect & ~write_n;
  assign abort_req = wr_en && (address == 3'd2) && writedata[1];
  assign start_req = wr_en && (address == 3'd2) && writedata[0] && !writedata[1];
  assign w1c       = (wr_en && (address == 3'd4)) ? writedata[2:0] : '0;
  assign busy      = (state != IDLE);
  assign cap       = (state == CAPTURE) && pix_edge && hr_s;
  assign unused_wd = &{1'b0, writedata[31:8], writedata[3]};

`ifdef PIXCAP_TESTPATTERN_EN
  logic       tp_en;
  logic [7:0] tp_val;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tp_en  <= 1'b0;
      tp_val <= '0;
    end else begin
      if (wr_en && (address == 3'd2)) tp_en <= writedata[3];
      if (vs_rise)  tp_val <= '0;
      else if (cap) tp_val <= tp_val + 8'd1;
    end
  end
  assign cap_byte = tp_en ? tp_val : data_s;
  assign tp_rd    = tp_en;
`else
  assign cap_byte = data_s;
  assign tp_rd    = 1'b0;
`endif

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
  always_comb begin
    full       = (level == DEPTH_L);
    pop        = rd_en && (address == 3'd0) && (level != '0);
    push       = !abort_req && ((cap && (byte_idx == 2'd3)) ||
                                ((state == FLUSH) && (byte_idx != 2'd0)));
    push_word  = (state == FLUSH) ? word_buf : {cap_byte, word_buf[23:0]};
    push_ok    = push && (!full || pop);
    push_drop  = push && full && !pop;
    level_next = level;
    if (abort_req)          level_next = '0;
    else if (push_ok && !pop) level_next = level + 1'b1;
    else if (!push_ok && pop) level_next = level - 1'b1;
    thr_hit = (threshold != 8'd0) && (9'(level_next) >= {1'b0, threshold}) &&
              (9'(level) < {1'b0, threshold});
    irq_set = {push_drop, thr_hit, state == FLUSH};
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    if (level != '0) rd_mux = mem[rd_ptr];
      3'd1:    rd_mux = {16'h0, 8'(level), 5'h0, overflow, done, busy};
      3'd2:    rd_mux = {28'h0, tp_rd, continuous, 2'b00};
      3'd3:    rd_mux = {29'h0, irq_mask};
      3'd4:    rd_mux = {29'h0, irq_status};
      3'd5:    rd_mux = {24'h0, threshold};
      3'd6:    rd_mux = {16'h0, byte_count};
      default: rd_mux = {20'h0, line_count};
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      readdata   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      word_buf   <= '0;
      byte_idx   <= '0;
      byte_count <= '0;
      line_count <= '0;
      threshold  <= '0;
      irq_mask   <= '0;
      irq_status <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      continuous <= 1'b0;
    end else begin
      if (rd_en) readdata <= rd_mux;
      irq_status <= (irq_status & ~w1c) | irq_set;
      if (wr_en) begin
        case (address)
          3'd2:    continuous <= writedata[2];
          3'd3:    irq_mask   <= writedata[2:0];
          3'd5:    threshold  <= writedata[7:0];
          default: ;
        endcase
      end
      if (abort_req) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_next;
      if (push_drop) overflow <= 1'b1;

      if (abort_req) begin
        state    <= IDLE;
        byte_idx <= '0;
        word_buf <= '0;
      end else begin
        unique case (state)
          IDLE: if (start_req) begin
            state      <= ARMED;
            byte_count <= '0;
            line_count <= '0;
            done       <= 1'b0;
            byte_idx   <= '0;
            word_buf   <= '0;
          end
          ARMED: if (vs_rise) state <= CAPTURE;
          CAPTURE: begin
            if (cap) begin
              if (byte_idx == 2'd3) word_buf <= '0;
              else word_buf[{byte_idx, 3'b000} +: 8] <= cap_byte;
              byte_idx <= byte_idx + 2'd1;
              if (byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;
            end
            if (hr_fall && (line_count != 12'hFFF)) line_count <= line_count + 12'd1;
            if (vs_rise) state <= FLUSH;
          end
          FLUSH: begin
            byte_idx <= '0;
            word_buf <= '0;
            done     <= 1'b1;
            if (continuous) begin
              state      <= ARMED;
              byte_count <= '0;
              line_count <= '0;
            end else begin
              state <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign irq = |(irq_status & irq_mask);
endmodule

// File: tb/tb_nios_pixel_capture.sv
// Testbench for nios_pixel_capture: register table plus frame-level sequences
// checked against a word scoreboard built from the bytes driven on the camera bus.
module tb_nios_pixel_capture;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic        pix_clk = 1'b0;
  logic        pix_vsync = 1'b0;
  logic        pix_href = 1'b0;
  logic [7:0]  pix_data = '0;

  always #5 clk = ~clk;

  nios_pixel_capture #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .pix_clk(pix_clk), .pix_vsync(pix_vsync), .pix_href(pix_href),
    .pix_data(pix_data)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } reg_vec_t;

  reg_vec_t    tbl [10];
  int          n_err = 0;
  int          n_checks = 0;
  logic [31:0] exp_q [$];
  logic [31:0] m_word;
  int          m_idx;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic check_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check(name, v, exp);
  endtask

  // Scoreboard model: little-endian packing, zero padding, drop when full.
  task automatic sb_start();
    m_idx = 0; m_word = '0;
  endtask

  task automatic sb_push(input logic [31:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
  endtask

  task automatic sb_byte(input logic [7:0] b);
    m_word[8*m_idx +: 8] = b;
    m_idx++;
    if (m_idx == 4) begin
      sb_push(m_word);
      sb_start();
    end
  endtask

  task automatic sb_flush();
    if (m_idx != 0) sb_push(m_word);
    sb_start();
  endtask

  task automatic read_data_sb(input string name);
    logic [31:0] v, e;
    bus_read(3'd0, v);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
    check(name, v, e);
  endtask

  task automatic pix_byte(input logic [7:0] b);
    pix_data = b;
    repeat (4) @(negedge clk);
    pix_clk = 1'b1;
    repeat (4) @(negedge clk);
    pix_clk = 1'b0;
    sb_byte(b);
  endtask

  // The read strobe lands on the same clk edge as the push of this byte's word.
  task automatic pix_byte_rd(input logic [7:0] b, output logic [31:0] d);
    pix_data = b;
    repeat (4) @(negedge clk);
    pix_clk = 1'b1;
    repeat (2) @(negedge clk);
    address = 3'd0; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
    @(negedge clk);
    pix_clk = 1'b0;
  endtask

  task automatic cam_vsync();
    pix_vsync = 1'b1;
    repeat (4) @(negedge clk);
    pix_vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_begin();
    bus_write(3'd2, 32'h1);
    sb_start();
    cam_vsync();
  endtask

  task automatic cam_line(input logic [7:0] first, input int n);
    pix_href = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) pix_byte(8'(first + i));
    pix_href = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    cam_vsync();
    repeat (4) @(negedge clk);
    sb_flush();
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] e;

    tbl[0] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0007, "irq_mask_rw"};
    tbl[1] = '{3'd5, 32'h1234_5678, 32'h0000_0078, "threshold_rw"};
    tbl[2] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0000, "status_ro"};
    tbl[3] = '{3'd6, 32'h0000_FFFF, 32'h0000_0000, "byte_count_ro"};
    tbl[4] = '{3'd7, 32'h0000_0FFF, 32'h0000_0000, "line_count_ro"};
    tbl[5] = '{3'd2, 32'h0000_000C, 32'h0000_0004, "control_cont"};
    tbl[6] = '{3'd2, 32'h0000_0000, 32'h0000_0000, "control_clr"};
    tbl[7] = '{3'd4, 32'h0000_0007, 32'h0000_0000, "irq_status_w1c_idle"};
    tbl[8] = '{3'd3, 32'h0000_0000, 32'h0000_0000, "irq_mask_clr"};
    tbl[9] = '{3'd5, 32'h0000_0000, 32'h0000_0000, "threshold_clr"};

    repeat (3) @(negedge clk);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    check_reg("reset_status", 3'd1, 32'h0);
    check_reg("reset_data_empty", 3'd0, 32'h0);

    for (int i = 0; i < 10; i++) begin
      bus_write(tbl[i].addr, tbl[i].wdata);
      check_reg(tbl[i].name, tbl[i].addr, tbl[i].exp);
    end

    // Two lines of four bytes
    frame_begin();
    cam_line(8'h11, 4);
    cam_line(8'h15, 4);
    frame_end();
    check_reg("b_status", 3'd1, 32'h0000_0202);
    check_reg("b_byte_count", 3'd6, 32'd8);
    check_reg("b_line_count", 3'd7, 32'd2);
    check_reg("b_irq_status", 3'd4, 32'h1);
    check("b_irq_masked", {31'h0, irq}, 32'h0);
    read_data_sb("b_word0");
    read_data_sb("b_word1");
    read_data_sb("b_empty");
    bus_write(3'd4, 32'h1);

    // Six bytes: second word zero-padded
    frame_begin();
    cam_line(8'hA1, 6);
    frame_end();
    check_reg("c_status_level2", 3'd1, 32'h0000_0202);
    check_reg("c_byte_count", 3'd6, 32'd6);
    read_data_sb("c_word0");
    read_data_sb("c_word1_padded");
    bus_write(3'd4, 32'h7);

    // Threshold 2: irq follows the level reaching 2
    bus_write(3'd5, 32'd2);
    bus_write(3'd3, 32'h2);
    frame_begin();
    pix_href = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) pix_byte(8'(8'h21 + i));
    check("d_irq_level1", {31'h0, irq}, 32'h0);
    for (int i = 4; i < 8; i++) pix_byte(8'(8'h21 + i));
    check("d_irq_level2", {31'h0, irq}, 32'h1);
    pix_href = 1'b0;
    repeat (4) @(negedge clk);
    frame_end();
    read_data_sb("d_word0");
    read_data_sb("d_word1");
    bus_write(3'd4, 32'h3);
    check("d_irq_cleared", {31'h0, irq}, 32'h0);

    // Full FIFO with a pop on the same edge as a push: no overflow, no re-trigger
    bus_write(3'd3, 32'h0);
    bus_write(3'd5, 32'd4);
    frame_begin();
    pix_href = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 16; i++) pix_byte(8'(8'h31 + i));
    check_reg("e_irq_status_thr", 3'd4, 32'h2);
    bus_write(3'd4, 32'h2);
    check_reg("e_irq_status_w1c", 3'd4, 32'h0);
    for (int i = 16; i < 19; i++) pix_byte(8'(8'h31 + i));
    pix_byte_rd(8'h44, v);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
    check("e_pop_during_push", v, e);
    sb_byte(8'h44);
    check_reg("e_irq_status_same_cycle", 3'd4, 32'h0);
    check_reg("e_status_full", 3'd1, 32'h0000_0401);
    pix_href = 1'b0;
    repeat (4) @(negedge clk);
    frame_end();
    for (int i = 0; i < 4; i++) read_data_sb("e_word");
    check_reg("e_irq_status_done", 3'd4, 32'h1);
    bus_write(3'd4, 32'h7);
    bus_write(3'd5, 32'd0);

    // 20 bytes into a 4-word FIFO with no reads
    bus_write(3'd3, 32'h4);
    frame_begin();
    cam_line(8'h61, 20);
    frame_end();
    check("f_irq_overflow", {31'h0, irq}, 32'h1);
    check_reg("f_status", 3'd1, 32'h0000_0406);
    check_reg("f_irq_status", 3'd4, 32'h5);
    bus_write(3'd4, 32'h4);
    check("f_irq_after_w1c", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 4; i++) read_data_sb("f_word");
    read_data_sb("f_empty");

    // Abort mid-capture with three words and a partial word queued
    bus_write(3'd3, 32'h0);
    frame_begin();
    pix_href = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 14; i++) pix_byte(8'(8'h51 + i));
    check_reg("g_status_busy", 3'd1, 32'h0000_0305);
    bus_write(3'd2, 32'h2);
    exp_q.delete();
    sb_start();
    check_reg("g_status_aborted", 3'd1, 32'h0000_0004);
    read_data_sb("g_empty_after_abort");
    pix_href = 1'b0;
    repeat (4) @(negedge clk);
    frame_begin();
    cam_line(8'hC1, 4);
    frame_end();
    read_data_sb("g_clean_word");
    check_reg("g_byte_count", 3'd6, 32'd4);

    // Asynchronous reset in the middle of a capture
    bus_write(3'd3, 32'h1);
    check("h_irq_before_reset", {31'h0, irq}, 32'h1);
    frame_begin();
    pix_href = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) pix_byte(8'(8'h71 + i));
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("h_reset_readdata", readdata, 32'h0);
    check("h_reset_irq", {31'h0, irq}, 32'h0);
    exp_q.delete();
    sb_start();
    pix_href = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_reg("h_status", 3'd1, 32'h0);
    check_reg("h_irq_status", 3'd4, 32'h0);
    read_data_sb("h_empty");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
